// File: rtl/issue_stage.sv
// Dual-issue pairing plus two-slot issue register between the instruction buffer and execute.
// Optional DIFFTEST_EN adds difftest payload registers and a running issue counter.
package issue_pkg;
    typedef enum logic [2:0] {OP_ALU, OP_MEM, OP_BR, OP_MUL, OP_DIV, OP_CSR, OP_MISC} optype_t;
    typedef enum logic [4:0] {
        OPC_NOP, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_LD_W, OPC_ST_W, OPC_BEQ, OPC_BNE,
        OPC_JIRL, OPC_MUL_W, OPC_DIV_W, OPC_CSRRD, OPC_CSRWR, OPC_ERTN, OPC_IDLE, OPC_IBAR,
        OPC_DBAR, OPC_SYSCALL
    } opcode_t;
    typedef enum logic [2:0] {BR_NONE, BR_COND, BR_JMP, BR_CALL, BR_RET} br_type_t;
    typedef enum logic [3:0] {EXC_NONE, EXC_SYS, EXC_BRK, EXC_INE, EXC_ADEF, EXC_PIF} excp_t;
    typedef logic [13:0] csr_addr_t;

    typedef struct packed {
        logic        commit;
        logic [31:0] inst;
        logic [31:0] wdata;
    } difftest_t;

    typedef struct packed {
        logic [31:0] pc;
        optype_t     optype;
        opcode_t     opcode;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic        pred_br_taken;
        logic [31:0] pred_br_target;
        br_type_t    br_type;
        logic        br_condition;
        logic [31:0] br_target;
        logic        br_taken;
        logic        have_excp;
        excp_t       excp_type;
        csr_addr_t   csr_addr;
        logic        csr_wr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        src2_is_imm;
    } slot_t;

    function automatic logic is_load(input slot_t s);
        return (s.optype == OP_MEM) && (s.dest != 5'd0);
    endfunction

    function automatic logic reads_reg(input slot_t s, input logic [4:0] r);
        return (r != 5'd0) && ((s.r1 == r) || (!s.src2_is_imm && (s.r2 == r)));
    endfunction

    function automatic logic is_serial(input slot_t s);
        return (s.optype == OP_CSR) || s.have_excp ||
               (s.opcode inside {OPC_ERTN, OPC_IDLE, OPC_IBAR, OPC_DBAR});
    endfunction

    function automatic logic is_muldiv(input slot_t s);
        return (s.optype == OP_MUL) || (s.optype == OP_DIV);
    endfunction
endpackage

module issue_stage
    import issue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        i_a_valid,
    input  logic [31:0] i_a_pc,
    input  optype_t     i_a_optype,
    input  opcode_t     i_a_opcode,
    input  logic [4:0]  i_a_dest,
    input  logic [31:0] i_a_imm,
    input  logic        i_a_pred_br_taken,
    input  logic [31:0] i_a_pred_br_target,
    input  br_type_t    i_a_br_type,
    input  logic        i_a_br_condition,
    input  logic [31:0] i_a_br_target,
    input  logic        i_a_br_taken,
    input  logic        i_a_have_excp,
    input  excp_t       i_a_excp_type,
    input  csr_addr_t   i_a_csr_addr,
    input  logic        i_a_csr_wr,
    input  logic [4:0]  i_a_r1,
    input  logic [4:0]  i_a_r2,
    input  logic        i_a_src2_is_imm,
    input  logic        i_b_valid,
    input  logic [31:0] i_b_pc,
    input  optype_t     i_b_optype,
    input  opcode_t     i_b_opcode,
    input  logic [4:0]  i_b_dest,
    input  logic [31:0] i_b_imm,
    input  logic        i_b_pred_br_taken,
    input  logic [31:0] i_b_pred_br_target,
    input  br_type_t    i_b_br_type,
    input  logic        i_b_br_condition,
    input  logic [31:0] i_b_br_target,
    input  logic        i_b_br_taken,
    input  logic        i_b_have_excp,
    input  excp_t       i_b_excp_type,
    input  csr_addr_t   i_b_csr_addr,
    input  logic        i_b_csr_wr,
    input  logic [4:0]  i_b_r1,
    input  logic [4:0]  i_b_r2,
    input  logic        i_b_src2_is_imm,
    output logic [1:0]  o_size,
    input  logic        ex_allowin,
    input  logic        backend_empty,
`ifdef DIFFTEST_EN
    input  difftest_t   i_a_difftest,
    input  difftest_t   i_b_difftest,
    output difftest_t   o_a_difftest,
    output difftest_t   o_b_difftest,
    output logic [31:0] o_issue_cnt,
`endif
    output logic        o_a_valid,
    output logic [31:0] o_a_pc,
    output optype_t     o_a_optype,
    output opcode_t     o_a_opcode,
    output logic [4:0]  o_a_dest,
    output logic [31:0] o_a_imm,
    output logic        o_a_pred_br_taken,
    output logic [31:0] o_a_pred_br_target,
    output br_type_t    o_a_br_type,
    output logic        o_a_br_condition,
    output logic [31:0] o_a_br_target,
    output logic        o_a_br_taken,
    output logic        o_a_have_excp,
    output excp_t       o_a_excp_type,
    output csr_addr_t   o_a_csr_addr,
    output logic        o_a_csr_wr,
    output logic [4:0]  o_a_r1,
    output logic [4:0]  o_a_r2,
    output logic        o_a_src2_is_imm,
    output logic        o_b_valid,
    output logic [31:0] o_b_pc,
    output optype_t     o_b_optype,
    output opcode_t     o_b_opcode,
    output logic [4:0]  o_b_dest,
    output logic [31:0] o_b_imm,
    output logic        o_b_pred_br_taken,
    output logic [31:0] o_b_pred_br_target,
    output br_type_t    o_b_br_type,
    output logic        o_b_br_condition,
    output logic [31:0] o_b_br_target,
    output logic        o_b_br_taken,
    output logic        o_b_have_excp,
    output excp_t       o_b_excp_type,
    output csr_addr_t   o_b_csr_addr,
    output logic        o_b_csr_wr,
    output logic [4:0]  o_b_r1,
    output logic [4:0]  o_b_r2,
    output logic        o_b_src2_is_imm
);

    typedef enum logic {NORMAL, SERIAL} state_t;

    state_t state;
    slot_t  in_a, in_b, reg_a, reg_b;
    logic   a_vld, b_vld;
    logic   may_load, lu_a, lu_b, ser_a, ser_b, pair_ok, issue_a, issue_b;

    assign in_a = '{pc: i_a_pc, optype: i_a_optype, opcode: i_a_opcode, dest: i_a_dest,
                    imm: i_a_imm, pred_br_taken: i_a_pred_br_taken,
                    pred_br_target: i_a_pred_br_target, br_type: i_a_br_type,
                    br_condition: i_a_br_condition, br_target: i_a_br_target,
                    br_taken: i_a_br_taken, have_excp: i_a_have_excp,
                    excp_type: i_a_excp_type, csr_addr: i_a_csr_addr, csr_wr: i_a_csr_wr,
                    r1: i_a_r1, r2: i_a_r2, src2_is_imm: i_a_src2_is_imm};
    assign in_b = '{pc: i_b_pc, optype: i_b_optype, opcode: i_b_opcode, dest: i_b_dest,
                    imm: i_b_imm, pred_br_taken: i_b_pred_br_taken,
                    pred_br_target: i_b_pred_br_target, br_type: i_b_br_type,
                    br_condition: i_b_br_condition, br_target: i_b_br_target,
                    br_taken: i_b_br_taken, have_excp: i_b_have_excp,
                    excp_type: i_b_excp_type, csr_addr: i_b_csr_addr, csr_wr: i_b_csr_wr,
                    r1: i_b_r1, r2: i_b_r2, src2_is_imm: i_b_src2_is_imm};

    assign may_load = !a_vld || ex_allowin;

    // A load sitting in the issue register has no result to forward next cycle, so block its users.
    assign lu_a = (a_vld && is_load(reg_a) && reads_reg(in_a, reg_a.dest)) ||
                  (b_vld && is_load(reg_b) && reads_reg(in_a, reg_b.dest));
    assign lu_b = (a_vld && is_load(reg_a) && reads_reg(in_b, reg_a.dest)) ||
                  (b_vld && is_load(reg_b) && reads_reg(in_b, reg_b.dest));

    assign ser_a = is_serial(in_a);
    assign ser_b = is_serial(in_b);

    assign pair_ok = !ser_a && !ser_b && (in_a.optype != OP_BR) &&
                     !reads_reg(in_b, in_a.dest) &&
                     !((in_a.optype == OP_MEM) && (in_b.optype == OP_MEM)) &&
                     !(is_muldiv(in_a) && is_muldiv(in_b));

    assign issue_a = !reset && !flush && i_a_valid && may_load && (state == NORMAL) &&
                     !lu_a && (!ser_a || backend_empty);
    assign issue_b = issue_a && i_b_valid && !lu_b && pair_ok;
    assign o_size  = {1'b0, issue_a} + {1'b0, issue_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= NORMAL;
        end else if (flush) begin
            state <= NORMAL;
        end else begin
            case (state)
                NORMAL:  if (issue_a && ser_a) state <= SERIAL;
                SERIAL:  if (may_load && backend_empty) state <= NORMAL;
                default: state <= NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_vld <= 1'b0;
            b_vld <= 1'b0;
            reg_a <= '0;
            reg_b <= '0;
        end else if (flush) begin
            a_vld <= 1'b0;
            b_vld <= 1'b0;
        end else if (may_load) begin
            a_vld <= issue_a;
            b_vld <= issue_b;
            reg_a <= in_a;
            reg_b <= in_b;
        end
    end

`ifdef DIFFTEST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_a_difftest <= '0;
            o_b_difftest <= '0;
            o_issue_cnt  <= 32'd0;
        end else begin
            o_issue_cnt <= o_issue_cnt + {30'd0, o_size};
            if (!flush && may_load) begin
                o_a_difftest <= i_a_difftest;
                o_b_difftest <= i_b_difftest;
            end
        end
    end
`endif

    assign o_a_valid          = a_vld;
    assign o_a_pc             = reg_a.pc;
    assign o_a_optype         = reg_a.optype;
    assign o_a_opcode         = reg_a.opcode;
    assign o_a_dest           = reg_a.dest;
    assign o_a_imm            = reg_a.imm;
    assign o_a_pred_br_taken  = reg_a.pred_br_taken;
    assign o_a_pred_br_target = reg_a.pred_br_target;
    assign o_a_br_type        = reg_a.br_type;
    assign o_a_br_condition   = reg_a.br_condition;
    assign o_a_br_target      = reg_a.br_target;
    assign o_a_br_taken       = reg_a.br_taken;
    assign o_a_have_excp      = reg_a.have_excp;
    assign o_a_excp_type      = reg_a.excp_type;
    assign o_a_csr_addr       = reg_a.csr_addr;
    assign o_a_csr_wr         = reg_a.csr_wr;
    assign o_a_r1             = reg_a.r1;
    assign o_a_r2             = reg_a.r2;
    assign o_a_src2_is_imm    = reg_a.src2_is_imm;

    assign o_b_valid          = b_vld;
    assign o_b_pc             = reg_b.pc;
    assign o_b_optype         = reg_b.optype;
    assign o_b_opcode         = reg_b.opcode;
    assign o_b_dest           = reg_b.dest;
    assign o_b_imm            = reg_b.imm;
    assign o_b_pred_br_taken  = reg_b.pred_br_taken;
    assign o_b_pred_br_target = reg_b.pred_br_target;
    assign o_b_br_type        = reg_b.br_type;
    assign o_b_br_condition   = reg_b.br_condition;
    assign o_b_br_target      = reg_b.br_target;
    assign o_b_br_taken       = reg_b.br_taken;
    assign o_b_have_excp      = reg_b.have_excp;
    assign o_b_excp_type      = reg_b.excp_type;
    assign o_b_csr_addr       = reg_b.csr_addr;
    assign o_b_csr_wr         = reg_b.csr_wr;
    assign o_b_r1             = reg_b.r1;
    assign o_b_r2             = reg_b.r2;
    assign o_b_src2_is_imm    = reg_b.src2_is_imm;

endmodule

// File: doc/issue_stage.md
# issue_stage

Dual-issue pairing and issue-register stage between the instruction buffer and the execute stage. Each cycle it inspects the two head entries of the instruction buffer, applies load-use, intra-pair, structural and serialization rules, and returns how many it consumed. Accepted instructions are captured into a two-slot issue register that feeds execute under a stall/flush handshake.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: pipeline redirect (branch mispredict or exception).
- `i_a_valid`, `i_b_valid` in 1: buffer head entries 0 and 1 are valid.
- `i_a_*`, `i_b_*` in: per-slot fields `pc[31:0]`, `optype` (optype_t), `opcode` (opcode_t), `dest[4:0]`, `imm[31:0]`, `pred_br_taken`, `pred_br_target[31:0]`, `br_type` (br_type_t), `br_condition`, `br_target[31:0]`, `br_taken`, `have_excp`, `excp_type` (excp_t), `csr_addr` (csr_addr_t), `csr_wr`, `r1[4:0]`, `r2[4:0]`, `src2_is_imm`.
- `o_size` out 2: entries consumed this cycle (0, 1 or 2). Combinational. Feeds the buffer's pop count.
- `ex_allowin` in 1: execute accepts the issue register this cycle.
- `backend_empty` in 1: no instruction is in flight past issue.
- `o_a_valid`, `o_b_valid` out 1: issue register slots are valid.
- `o_a_*`, `o_b_*` out: the 18 fields above, registered.

## Operation
- Hazard terms:
  - Load: `optype==OP_MEM` with `dest!=0`. The decoder guarantees `dest=0` for stores.
  - Source use: `r1` when `r1!=0`. `r2` when `r2!=0` and `!src2_is_imm`.
  - Load-use: a candidate's used source equals the `dest` of a valid load held in the issue register while it advances this cycle.
- `issue_a` requires all of:
  - `i_a_valid`.
  - Issue register may load (`!o_a_valid || ex_allowin`).
  - `state==NORMAL`.
  - No load-use hazard on a.
  - If a is serializing (`optype==OP_CSR`, `have_excp`, or `opcode` in {ERTN, IDLE, IBAR, DBAR}), `backend_empty` must also be high.
- `issue_b` requires `issue_a`, `i_b_valid`, no load-use hazard on b, and none of the following:
  - a or b is serializing.
  - a is OP_BR.
  - a.dest!=0 and a.dest matches a source used by b.
  - Both are OP_MEM.
  - Both are in {OP_MUL, OP_DIV}.
- `o_size = issue_a + issue_b`. It is 0 during `flush` and `reset`.
- Issue register update:
  - On `flush`: both valid bits clear.
  - Otherwise, when it may load: `o_a_valid<=issue_a`, `o_b_valid<=issue_b`, and fields load from the matching inputs.
  - Otherwise it holds.
  - Fields of invalid slots are don't-care.
- FSM states:
  - NORMAL: a serializing instruction issuing in slot a moves to SERIAL.
  - SERIAL: nothing issues. Moves to NORMAL when the issue register is empty or advancing and `backend_empty`.
  - `flush` forces NORMAL.

## Timing
- Reset values: `o_a_valid=0`, `o_b_valid=0`, state NORMAL, all output fields 0. `o_size=0` while reset is asserted.
- Latency: an instruction consumed in cycle N is on `o_*` in cycle N+1.
- Stall: with `ex_allowin=0` and the register valid, `o_*` holds and `o_size=0`.
- Load-use: the dependent instruction issues exactly one cycle after the load leaves the issue register (one bubble).
- Flush with simultaneous valid inputs: nothing is consumed. The register is empty next cycle.
- Reset asserted mid-stall: outputs clear immediately, asynchronously.

## Configuration
- `DIFFTEST_EN` defined:
  - Adds `i_a_difftest`, `i_b_difftest` in (difftest_t) and `o_a_difftest`, `o_b_difftest` out (difftest_t). They are registered alongside the slots with identical load, hold and flush rules.
  - Adds `o_issue_cnt` out 32: running count of issued instructions. It increments by `o_size`, wraps at 2^32, and resets to 0.
- `DIFFTEST_EN` undefined: these ports and the counter are absent. Behaviour is otherwise identical.

## Test plan
- Two independent OP_ALU instructions (a: dest=3; b: r1=4, r2=5), `ex_allowin=1` → `o_size=2`. Both appear as valid on `o_*` the next cycle.
- Pair a: dest=3, b: r1=3 → `o_size=1`. b issues alone one cycle later.
- Load (dest=7) in the issue register, head a uses r2=7, `src2_is_imm=0` → `o_size=0` for one cycle, then a issues. The same pattern with `src2_is_imm=1` → no stall.
- CSR instruction at head with `backend_empty=0` → `o_size=0` until `backend_empty=1`. It then issues alone, and `o_size=0` persists until the drain completes.
- `ex_allowin=0` for 3 cycles with the register full → outputs stable and `o_size=0`. `flush` in the 2nd cycle → both valids are 0 next cycle.
- With `DIFFTEST_EN`: issue 2+1+2 instructions → `o_issue_cnt=5`. Async `reset` pulse mid-cycle → all valids and the counter read 0 before the next edge.
